// File: rtl/ebpc_znz_encoder_pkg.sv
// ebpc_znz_encoder_pkg: shared constants and types for the EBPC ZNZ encoder slice.
//   DATA_W           activation / packed ZNZ word width
//   MAX_ZRLE_LEN     longest zero run carried by one run symbol
//   LOG_MAX_ZRLE_LEN width of the run-length field of a run symbol
//   LOG_MAX_WORDS    width of the optional non-zero statistics counter
//   ZSYM_W           width of a zero-run symbol ('0' + length-1)
//   INS_W            widest single-cycle insert (run symbol followed by a '1')
//   znz_enc_state_t  encoder FSM states
package ebpc_znz_encoder_pkg;
  localparam int DATA_W           = 8;
  localparam int MAX_ZRLE_LEN     = 16;
  localparam int LOG_MAX_ZRLE_LEN = $clog2(MAX_ZRLE_LEN);
  localparam int LOG_MAX_WORDS    = 24;
  localparam int ZSYM_W           = 1 + LOG_MAX_ZRLE_LEN;
  localparam int INS_W            = ZSYM_W + 1;
  localparam int BUF_W            = 2 * DATA_W;
  localparam int FILL_W           = $clog2(BUF_W + 1);
  localparam int RUN_W            = $clog2(MAX_ZRLE_LEN + 1);
  localparam int LEN_W            = $clog2(INS_W + 1);

  typedef enum logic {ST_ACTIVE, ST_FLUSH} znz_enc_state_t;
endpackage

// File: rtl/ebpc_znz_encoder_if.sv
// ebpc_znz_encoder_if: one DATA_W-wide valid/ready stream with an end-of-block flag.
//   data  payload word
//   last  end-of-block marker (unused on the nz stream, driven 0)
//   vld   source has a word
//   rdy   sink takes the word at the rising edge when vld is also high
//   master drives data/last/vld, slave drives rdy.
interface ebpc_znz_encoder_if;
  import ebpc_znz_encoder_pkg::*;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              vld;
  logic              rdy;

  modport master (output data, last, vld, input rdy);
  modport slave  (input data, last, vld, output rdy);
endinterface

// File: rtl/ebpc_znz_encoder_bit_packer.sv
// ebpc_znz_encoder_bit_packer: MSB-first bit packer into DATA_W words.
//   i_clk, i_rst          clock, async active-high reset
//   i_ins_en/bits/len     insert i_ins_len (0..INS_W) right-aligned bits this cycle
//   i_flush               the insert this cycle closes the block: pad the tail and
//                         mark the final word with o_last
//   o_space               at least INS_W free bits in the buffer
//   o_data/o_last/o_vld/i_rdy  registered packed-word output stream
module ebpc_znz_encoder_bit_packer
  import ebpc_znz_encoder_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ins_en,
  input  logic [INS_W-1:0]  i_ins_bits,
  input  logic [LEN_W-1:0]  i_ins_len,
  input  logic              i_flush,
  output logic              o_space,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_vld,
  input  logic              i_rdy
);
  localparam logic [FILL_W-1:0] FILL_WORD    = FILL_W'(DATA_W);
  localparam logic [FILL_W-1:0] FILL_MAX_INS = FILL_W'(BUF_W - INS_W);

  // r_buf is left-aligned: bit BUF_W-1 is the oldest bit; bits below r_fill are kept 0,
  // so a flushed tail is zero-padded for free.
  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic              r_flush;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_vld;

  logic              w_out_free;
  logic              w_load;
  logic              w_word_last;
  logic [BUF_W-1:0]  w_buf_base;
  logic [FILL_W-1:0] w_fill_base;
  logic [INS_W-1:0]  w_ins_al;
  logic [BUF_W-1:0]  w_ins_pos;
  logic [BUF_W-1:0]  w_buf_n;
  logic [FILL_W-1:0] w_fill_n;

  always_comb begin
    w_out_free  = !r_vld || i_rdy;
    // While flushing, a partial tail counts as a (padded) word.
    w_load      = w_out_free && ((r_fill >= FILL_WORD) || (r_flush && (r_fill != '0)));
    w_word_last = r_flush && (r_fill <= FILL_WORD);
    w_buf_base  = w_load ? (r_buf << DATA_W) : r_buf;
    w_fill_base = r_fill;
    if (w_load) w_fill_base = (r_fill >= FILL_WORD) ? (r_fill - FILL_WORD) : '0;
    // Left-align the new bits, then drop them right behind the surviving fill.
    w_ins_al    = i_ins_bits << (LEN_W'(INS_W) - i_ins_len);
    w_ins_pos   = {w_ins_al, {(BUF_W-INS_W){1'b0}}} >> w_fill_base;
    w_buf_n     = i_ins_en ? (w_buf_base | w_ins_pos) : w_buf_base;
    w_fill_n    = i_ins_en ? (w_fill_base + FILL_W'(i_ins_len)) : w_fill_base;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf   <= '0;
      r_fill  <= '0;
      r_flush <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_buf  <= w_buf_n;
      r_fill <= w_fill_n;
      if (i_flush)                    r_flush <= 1'b1;
      else if (w_load && w_word_last) r_flush <= 1'b0;
      if (w_load) begin
        r_data <= r_buf[BUF_W-1 -: DATA_W];
        r_last <= w_word_last;
        r_vld  <= 1'b1;
      end else if (i_rdy) begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign o_space = (r_fill <= FILL_MAX_INS);
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_vld   = r_vld;
endmodule

// File: rtl/ebpc_znz_encoder.sv
// ebpc_znz_encoder: splits an activation stream into a zero-run-length coded ZNZ
// bitstream (packed MSB-first into DATA_W words) and a stream of non-zero values.
//   clk_i, rst_i  clock, async active-high reset
//   i_act         slave:  activation words in, last marks end of block
//   o_nz          master: non-zero values (no framing, last driven 0)
//   o_znz         master: packed ZNZ words, last on the final word of a block
//   nz_cnt_o      non-zeros in the last completed block, saturating
//                 (only when EBPC_ZNZ_ENC_STATS_EN is defined)
// Symbols: non-zero -> '1'; zero run of length L -> '0' followed by L-1 in
// LOG_MAX_ZRLE_LEN bits.
module ebpc_znz_encoder
  import ebpc_znz_encoder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  ebpc_znz_encoder_if.slave  i_act,
  ebpc_znz_encoder_if.master o_nz,
  ebpc_znz_encoder_if.master o_znz
`ifdef EBPC_ZNZ_ENC_STATS_EN
  ,
  output logic [LOG_MAX_WORDS-1:0] nz_cnt_o
`endif
);
  znz_enc_state_t    r_state, w_state_n;
  logic [RUN_W-1:0]  r_run, w_run_n;
  logic [DATA_W-1:0] r_nz;
  logic              r_nz_vld;

  logic              w_pk_space;
  logic              w_nz_free;
  logic              w_rdy;
  logic              w_acc;
  logic              w_is_zero;
  logic              w_flush;
  logic              w_ins_en;
  logic [INS_W-1:0]  w_ins_bits;
  logic [LEN_W-1:0]  w_ins_len;
  logic [RUN_W-1:0]  w_run_inc;
  logic [RUN_W-1:0]  w_run_dec;
  logic              w_znz_done;

  assign w_nz_free  = !r_nz_vld || o_nz.rdy;
  assign w_rdy      = !rst_i && (r_state == ST_ACTIVE) && w_pk_space && w_nz_free;
  assign w_acc      = i_act.vld && w_rdy;
  assign w_is_zero  = (i_act.data == '0);
  assign w_flush    = w_acc && i_act.last;
  assign w_run_inc  = r_run + RUN_W'(1);
  assign w_run_dec  = r_run - RUN_W'(1);
  assign w_znz_done = o_znz.vld && o_znz.rdy && o_znz.last;

  // Symbol formation. For a zero the run including this word is r_run+1, so its
  // length field is r_run; for a non-zero the pending run is r_run, field r_run-1.
  always_comb begin
    w_ins_en   = 1'b0;
    w_ins_bits = '0;
    w_ins_len  = '0;
    w_run_n    = r_run;
    if (w_acc) begin
      if (w_is_zero) begin
        if ((w_run_inc == RUN_W'(MAX_ZRLE_LEN)) || i_act.last) begin
          w_ins_en   = 1'b1;
          w_ins_bits = INS_W'({1'b0, r_run[LOG_MAX_ZRLE_LEN-1:0]});
          w_ins_len  = LEN_W'(ZSYM_W);
          w_run_n    = '0;
        end else begin
          w_run_n    = w_run_inc;
        end
      end else begin
        w_ins_en = 1'b1;
        w_run_n  = '0;
        if (r_run != '0) begin
          w_ins_bits = {1'b0, w_run_dec[LOG_MAX_ZRLE_LEN-1:0], 1'b1};
          w_ins_len  = LEN_W'(INS_W);
        end else begin
          w_ins_bits = INS_W'(1);
          w_ins_len  = LEN_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_ACTIVE: if (w_flush)    w_state_n = ST_FLUSH;
      ST_FLUSH:  if (w_znz_done) w_state_n = ST_ACTIVE;
      default:                   w_state_n = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_ACTIVE;
      r_run    <= '0;
      r_nz     <= '0;
      r_nz_vld <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_run   <= w_run_n;
      if (w_acc && !w_is_zero) begin
        r_nz     <= i_act.data;
        r_nz_vld <= 1'b1;
      end else if (o_nz.rdy) begin
        r_nz_vld <= 1'b0;
      end
    end
  end

  ebpc_znz_encoder_bit_packer u_packer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_ins_en   (w_ins_en),
    .i_ins_bits (w_ins_bits),
    .i_ins_len  (w_ins_len),
    .i_flush    (w_flush),
    .o_space    (w_pk_space),
    .o_data     (o_znz.data),
    .o_last     (o_znz.last),
    .o_vld      (o_znz.vld),
    .i_rdy      (o_znz.rdy)
  );

  assign i_act.rdy = w_rdy;
  assign o_nz.data = r_nz;
  assign o_nz.vld  = r_nz_vld;
  assign o_nz.last = 1'b0;

`ifdef EBPC_ZNZ_ENC_STATS_EN
  // Running count for the open block; published when its last ZNZ word leaves.
  logic [LOG_MAX_WORDS-1:0] r_nz_acc;
  logic [LOG_MAX_WORDS-1:0] r_nz_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nz_acc <= '0;
      r_nz_cnt <= '0;
    end else if (w_znz_done) begin
      r_nz_cnt <= r_nz_acc;
      r_nz_acc <= '0;
    end else if (w_acc && !w_is_zero && (r_nz_acc != '1)) begin
      r_nz_acc <= r_nz_acc + LOG_MAX_WORDS'(1);
    end
  end

  assign nz_cnt_o = r_nz_cnt;
`endif
endmodule

// File: tb/tb_ebpc_znz_encoder.sv
// tb_ebpc_znz_encoder: directed-vector bench for ebpc_znz_encoder with random
// output back-pressure and input gaps. Expected words are hand-computed.
module tb_ebpc_znz_encoder;
  import ebpc_znz_encoder_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ebpc_znz_encoder_if act_if ();
  ebpc_znz_encoder_if nz_if ();
  ebpc_znz_encoder_if znz_if ();

`ifdef EBPC_ZNZ_ENC_STATS_EN
  logic [LOG_MAX_WORDS-1:0] nz_cnt;
`endif

  ebpc_znz_encoder dut (
    .clk_i (clk),
    .rst_i (rst),
    .i_act (act_if),
    .o_nz  (nz_if),
    .o_znz (znz_if)
`ifdef EBPC_ZNZ_ENC_STATS_EN
    ,
    .nz_cnt_o (nz_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output back-pressure; hold forces znz_rdy low.
  logic hold;
  always @(posedge clk) begin
    #1;
    nz_if.rdy  = ($urandom_range(0, 3) != 0);
    znz_if.rdy = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Handshake monitor: signals are stable from the falling edge to the next rising edge.
  logic [8:0] znz_q[$];
  logic [7:0] nz_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (znz_if.vld && znz_if.rdy) znz_q.push_back({znz_if.last, znz_if.data});
      if (nz_if.vld && nz_if.rdy)   nz_q.push_back(nz_if.data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  bit gaps;
  task automatic put(input logic [7:0] d, input logic l);
    int n;
    act_if.data = d;
    act_if.last = l;
    act_if.vld  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (act_if.rdy) break;
      n++;
      if (n > 500) begin
        chk("put_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    act_if.vld  = 1'b0;
    act_if.last = 1'b0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  int zbase;
  int nbase;
  logic [8:0] ez[$];
  logic [7:0] en[$];

  task automatic wait_lasts(input string tag, input int want);
    int got;
    int n;
    n = 0;
    forever begin
      got = 0;
      for (int i = zbase; i < znz_q.size(); i++) if (znz_q[i][8]) got++;
      if (got >= want) break;
      n++;
      if (n > 3000) begin
        chk({tag, "_timeout"}, got, want);
        break;
      end
      @(negedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_block(input string tag);
    chk({tag, "_znz_cnt"}, znz_q.size() - zbase, ez.size());
    for (int i = 0; i < ez.size(); i++)
      if (zbase + i < znz_q.size()) chk({tag, "_znz"}, znz_q[zbase+i], ez[i]);
    chk({tag, "_nz_cnt"}, nz_q.size() - nbase, en.size());
    for (int i = 0; i < en.size(); i++)
      if (nbase + i < nz_q.size()) chk({tag, "_nz"}, nz_q[nbase+i], en[i]);
    zbase = znz_q.size();
    nbase = nz_q.size();
    ez.delete();
    en.delete();
  endtask

  task automatic case1();
    put(8'h05, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h07, 1'b1);
    ez.push_back(9'h186);
    en.push_back(8'h05); en.push_back(8'h07);
  endtask

  task automatic case3(input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < 8; i++) put(8'h01, i == 7);
      ez.push_back(9'h1FF);
      for (int i = 0; i < 8; i++) en.push_back(8'h01);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_znz_vld"}, znz_if.vld, 0);
    chk({tag, "_nz_vld"}, nz_if.vld, 0);
    chk({tag, "_rdy"}, act_if.rdy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    bit         have;
    bit         moved;
    bit         saw_low;
    int         n;
    checks = 0; errors = 0;
    zbase = 0; nbase = 0;
    hold = 1'b0; gaps = 1'b1;
    act_if.data = '0; act_if.last = 1'b0; act_if.vld = 1'b0;
    nz_if.rdy = 1'b0; znz_if.rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_znz_data", znz_if.data, 0);
    chk("reset_nz_data", nz_if.data, 0);
`ifdef EBPC_ZNZ_ENC_STATS_EN
    chk("reset_nz_cnt", nz_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 05,00,00,07(last) -> 1 00001 1 + pad = 0x86
    case1();
    wait_lasts("c1", 1);
    check_block("c1");
`ifdef EBPC_ZNZ_ENC_STATS_EN
    chk("c1_nz_cnt", nz_cnt, 2);
`endif

    // 3: eight non-zeros fill exactly one word, no pad word
    case3(1);
    wait_lasts("c3", 1);
    check_block("c3");
`ifdef EBPC_ZNZ_ENC_STATS_EN
    chk("c3_nz_cnt", nz_cnt, 8);
`endif

    // 2: 17 zeros -> 01111 00000 -> 0x78, then 0x00 last
    for (int i = 0; i < 17; i++) put(8'h00, i == 16);
    ez.push_back(9'h078); ez.push_back(9'h100);
    wait_lasts("c2", 1);
    check_block("c2");
`ifdef EBPC_ZNZ_ENC_STATS_EN
    chk("c2_nz_cnt", nz_cnt, 0);
`endif

    // 4: hold znz back-pressure 20 cycles once a word is waiting
    hold = 1'b1; gaps = 1'b0;
    have = 0; moved = 0; saw_low = 0;
    fork
      case3(3);
      begin
        n = 0;
        while (!znz_if.vld && n < 200) begin @(negedge clk); n++; end
        held = znz_if.data;
        have = znz_if.vld;
        repeat (20) begin
          @(negedge clk);
          if (!znz_if.vld || znz_if.data != held) moved = 1;
          if (!act_if.rdy) saw_low = 1;
        end
        hold = 1'b0;
      end
    join
    gaps = 1'b1;
    chk("c4_word_waiting", have, 1);
    chk("c4_znz_stable", moved, 0);
    chk("c4_rdy_dropped", saw_low, 1);
    wait_lasts("c4", 3);
    check_block("c4");

    // 5: reset mid-block discards the partial block
    put(8'h03, 1'b0); put(8'h00, 1'b0); put(8'h09, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("c5_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("c5_rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    chk("c5_no_partial_znz", znz_q.size() - zbase, 0);
    nbase = nz_q.size();
    @(posedge clk); #1;
    case1();
    wait_lasts("c5", 1);
    check_block("c5");
`ifdef EBPC_ZNZ_ENC_STATS_EN
    chk("c5_nz_cnt", nz_cnt, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
